// File: rtl/ipif_reg_initiator_pkg.sv
// Shared definitions for the IPIF register initiator: state encoding,
// timeout response word and timeout counter width.
package nf10_ipif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_GAP    = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int unsigned CNT_W        = 16;

endpackage

// File: rtl/ipif_reg_initiator_if.sv
// Command/response handshake plus IPIF register-slave signals.
// master = the initiator, slave = the agent/register file around it.
interface ipif_reg_initiator_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rnw;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_data;
  logic [DW/8-1:0]   cmd_be;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_error;

  logic              Bus2IP_CS;
  logic              Bus2IP_RNW;
  logic [AW-1:0]     Bus2IP_Addr;
  logic [DW-1:0]     Bus2IP_Data;
  logic [DW/8-1:0]   Bus2IP_BE;
  logic [DW-1:0]     IP2Bus_Data;
  logic              IP2Bus_RdAck;
  logic              IP2Bus_WrAck;
  logic              IP2Bus_Error;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_data, cmd_be, rsp_ready,
           IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
           Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_data, cmd_be, rsp_ready,
           IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
           Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr, Bus2IP_Data, Bus2IP_BE
  );
endinterface

// File: rtl/ipif_reg_initiator.sv
// Single-outstanding register access initiator for an IPIF slave:
// command in, Bus2IP access with ack/timeout, one response out.
module ipif_reg_initiator
  import nf10_ipif_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                 Bus2IP_Clk,
  input  logic                 Bus2IP_Resetn,
  ipif_reg_initiator_if.master bus
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned BW = DW / 8;
  // Counter holds completed no-ack cycles; the cycle that would make it
  // reach TIMEOUT_CYCLES is the last ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             rst_done_q, rst_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d;
  logic             rnw_q, rnw_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [BW-1:0]    be_q, be_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             ack_ok;
  logic             cmd_ready;

  always_comb begin
    state_d    = state_q;
    rst_done_d = 1'b1;
    cnt_d      = cnt_q;
    cs_d       = cs_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ack_ok     = rnw_q ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck;
    cmd_ready  = (state_q == ST_IDLE) && rst_done_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          rnw_d   = bus.cmd_rnw;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_data;
          be_d    = bus.cmd_be;
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // An ack in the final cycle takes priority over the timeout.
        if (ack_ok) begin
          rdata_d = rnw_q ? bus.IP2Bus_Data : '0;
          err_d   = bus.IP2Bus_Error;
          cs_d    = 1'b0;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = DW'(TIMEOUT_DATA);
          err_d   = 1'b1;
          cs_d    = 1'b0;
          state_d = ST_GAP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP:  state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
      cnt_q      <= '0;
      cs_q       <= 1'b0;
      rnw_q      <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= rst_done_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_data    = rdata_q;
  assign bus.rsp_error   = err_q;
  assign bus.Bus2IP_CS   = cs_q;
  assign bus.Bus2IP_RNW  = rnw_q;
  assign bus.Bus2IP_Addr = addr_q;
  assign bus.Bus2IP_Data = wdata_q;
  assign bus.Bus2IP_BE   = be_q;

endmodule

// File: tb/tb_ipif_reg_initiator.sv
// Bench for ipif_reg_initiator: registered register-file stub
// (1 WO, 8 RW, 12 RO words) and a transaction-level expectation model.
module tb_ipif_reg_initiator;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned TO    = 8;
  localparam int unsigned N_RW  = 8;
  localparam int unsigned N_REG = 21;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks   = 0;
  int unsigned passes   = 0;
  int unsigned exp_rsp  = 0;
  int unsigned rsp_seen = 0;

  int unsigned ack_after = 1;
  logic        err_inj   = 1'b0;
  logic        swap_ack  = 1'b0;
  logic [31:0] slv_mem [N_REG] = '{default: '0};
  logic [31:0] ref_mem [N_REG];
  int unsigned cs_cnt = 0;
  logic [31:0] last_data;

  always #5 clk = ~clk;

  ipif_reg_initiator_if #(.DW(DW), .AW(AW)) bus ();

  ipif_reg_initiator #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Bus2IP_Clk(clk),
    .Bus2IP_Resetn(rst_n),
    .bus(bus)
  );

  function automatic logic [31:0] ro_val(input int unsigned idx);
    return 32'hA500_0000 + 32'(idx) * 32'h0000_0111;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Registered slave: acks the cycle after it has seen CS for ack_after
  // cycles, and keeps acking while CS stays high (hence the GAP duplicate).
  always @(posedge clk) begin
    int unsigned idx;
    bus.IP2Bus_RdAck <= 1'b0;
    bus.IP2Bus_WrAck <= 1'b0;
    bus.IP2Bus_Error <= 1'b0;
    bus.IP2Bus_Data  <= '0;
    idx = 32'(bus.Bus2IP_Addr >> 2);
    if (!bus.Bus2IP_CS) begin
      cs_cnt = 0;
    end else begin
      cs_cnt = cs_cnt + 1;
      if (cs_cnt >= ack_after && idx < N_REG) begin
        if (bus.Bus2IP_RNW) begin
          if (idx != 0) begin
            if (swap_ack) bus.IP2Bus_WrAck <= 1'b1;
            else          bus.IP2Bus_RdAck <= 1'b1;
            bus.IP2Bus_Data  <= (idx <= N_RW) ? slv_mem[idx] : ro_val(idx);
            bus.IP2Bus_Error <= err_inj;
          end
        end else begin
          if (swap_ack) begin
            bus.IP2Bus_RdAck <= 1'b1;
          end else begin
            bus.IP2Bus_WrAck <= 1'b1;
            if (idx >= 1 && idx <= N_RW)
              slv_mem[idx] <= merge(slv_mem[idx], bus.Bus2IP_Data, bus.Bus2IP_BE);
          end
          bus.IP2Bus_Error <= err_inj;
        end
      end
    end
  end

  always @(posedge clk)
    if (rst_n && bus.rsp_valid && bus.rsp_ready) rsp_seen <= rsp_seen + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_cmd(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int unsigned hold);
    int unsigned idx;
    logic        acked, tmo;
    int unsigned exp_cs, lat, cs_cycles, n;
    logic [31:0] exp_d;
    logic        exp_e;
    idx = addr >> 2;
    // Expectation from the access rules
    if (swap_ack) acked = 1'b0;
    else if (rnw) acked = (idx != 0);
    else          acked = 1'b1;
    tmo    = !acked || (ack_after + 1 > TO);
    exp_cs = tmo ? TO : ack_after + 1;
    if (tmo) begin
      exp_d = TO_DATA;
      exp_e = 1'b1;
    end else begin
      exp_e = err_inj;
      exp_d = rnw ? ((idx <= N_RW) ? ref_mem[idx] : ro_val(idx)) : 32'h0;
    end
    // The slave commits a write once it has seen CS for ack_after cycles.
    if (!rnw && !swap_ack && ack_after <= TO && idx >= 1 && idx <= N_RW)
      ref_mem[idx] = merge(ref_mem[idx], data, be);

    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rnw   = rnw;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_be    = be;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bus_cs", bus.Bus2IP_CS, 1);
    chk("bus_addr", bus.Bus2IP_Addr, addr);
    chk("bus_rnw", bus.Bus2IP_RNW, rnw);
    chk("bus_be", bus.Bus2IP_BE, be);
    if (!rnw) chk("bus_wdata", bus.Bus2IP_Data, data);

    lat = 1;
    cs_cycles = 0;
    while (!bus.rsp_valid && lat < 64) begin
      if (bus.Bus2IP_CS) cs_cycles++;
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("latency", lat, exp_cs + 2);
    chk("cs_cycles", cs_cycles, exp_cs);
    chk("rsp_data", bus.rsp_data, exp_d);
    chk("rsp_error", bus.rsp_error, exp_e);
    last_data = bus.rsp_data;

    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, exp_d);
      chk("bp_error", bus.rsp_error, exp_e);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_cs", bus.Bus2IP_CS, 0);
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_rsp++;
    chk("rsp_dropped", bus.rsp_valid, 0);
    chk("idle_ready", bus.cmd_ready, 1);
    chk("addr_hold", bus.Bus2IP_Addr, addr);
  endtask

  initial begin
    logic        r;
    int unsigned ix, stale;
    for (int i = 0; i < int'(N_REG); i++) ref_mem[i] = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_rnw   = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.cmd_be    = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_cs", bus.Bus2IP_CS, 0);
    chk("rst_rnw", bus.Bus2IP_RNW, 1);
    chk("rst_addr", bus.Bus2IP_Addr, 0);
    chk("rst_data", bus.Bus2IP_Data, 0);
    chk("rst_be", bus.Bus2IP_BE, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.cmd_ready, 1);

    // Write / read back, then the never-acking WO word
    do_cmd(1'b0, 32'h4, 32'h1234_5678, 4'hF, 0);
    do_cmd(1'b1, 32'h4, 32'h0, 4'hF, 0);
    chk("readback_const", last_data, 32'h1234_5678);
    do_cmd(1'b1, 32'h0, 32'h0, 4'hF, 0);
    chk("wo_timeout_const", last_data, 32'hDEAD_BEEF);
    do_cmd(1'b0, 32'h30, 32'hFFFF_FFFF, 4'hF, 0);

    // Backpressure on a normal read
    do_cmd(1'b1, 32'h4, 32'h0, 4'hF, 10);

    // Ack on the last allowed cycle, then one cycle too late
    ack_after = TO - 1;
    do_cmd(1'b1, 32'h4, 32'h0, 4'hF, 0);
    ack_after = TO;
    do_cmd(1'b1, 32'h4, 32'h0, 4'hF, 0);
    ack_after = 1;

    // Wrong-type acks only
    swap_ack = 1'b1;
    do_cmd(1'b1, 32'h8, 32'h0, 4'hF, 0);
    do_cmd(1'b0, 32'h8, 32'hCAFE_F00D, 4'hF, 0);
    swap_ack = 1'b0;

    // Slave error returned with the ack
    err_inj = 1'b1;
    do_cmd(1'b0, 32'h10, 32'h5555_AAAA, 4'h5, 1);
    err_inj = 1'b0;

    // Reset while CS is high
    ack_after = 1000;
    bus.cmd_valid = 1'b1;
    bus.cmd_rnw   = 1'b1;
    bus.cmd_addr  = 32'h4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_cs_high", bus.Bus2IP_CS, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cs_drop", bus.Bus2IP_CS, 0);
    chk("async_ready_low", bus.cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_after = 1;
    @(negedge clk);
    chk("ready_after_rst2", bus.cmd_ready, 1);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.Bus2IP_CS) stale++;
    end
    chk("no_stale_rsp", stale, 0);

    // Randomised traffic
    for (int k = 0; k < 40; k++) begin
      r  = 1'($urandom_range(0, 1));
      ix = $urandom_range(0, N_REG - 1);
      ack_after = ($urandom_range(0, 4) == 0) ? $urandom_range(2, TO + 1) : 1;
      err_inj   = ($urandom_range(0, 7) == 0);
      do_cmd(r, 32'(ix * 4), $urandom, 4'($urandom), $urandom_range(0, 2));
    end
    ack_after = 1;
    err_inj   = 1'b0;

    // Final sweep of every RW word against the model
    for (int unsigned w = 1; w <= N_RW; w++) do_cmd(1'b1, 32'(w * 4), 32'h0, 4'hF, 0);

    chk("rsp_count", rsp_seen, exp_rsp);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ipif_reg_initiator.md
# ipif_reg_initiator

Register-access initiator for the IPIF bus: accepts single read/write commands on a valid/ready command port, drives the Bus2IP_* side of one IPIF register slave, waits for IP2Bus_RdAck/IP2Bus_WrAck or a timeout, and returns data and status on a valid/ready response port. It sits between a control agent (host bridge, MicroBlaze shim or test sequencer) and any pcore register file in the standard library.

## Interface
- C_S_AXI_DATA_WIDTH, 32: bus data width.
- C_S_AXI_ADDR_WIDTH, 32: bus address width.
- TIMEOUT_CYCLES, 256: cycles CS may stay high without an ack before the access is aborted; legal range 2..65535.
- Bus2IP_Clk  in  1: the only clock.
- Bus2IP_Resetn  in  1: reset, asynchronous and active-low.
- cmd_valid / cmd_ready  in / out  1 each: command handshake.
- cmd_rnw  in  1: 1 selects read, 0 selects write.
- cmd_addr  in  C_S_AXI_ADDR_WIDTH: byte address.
- cmd_data  in  C_S_AXI_DATA_WIDTH: write data.
- cmd_be  in  C_S_AXI_DATA_WIDTH/8: byte enables.
- rsp_valid / rsp_ready  out / in  1 each: response handshake.
- rsp_data  out  C_S_AXI_DATA_WIDTH: read data; 0 for writes.
- rsp_error  out  1: set on timeout or when IP2Bus_Error is sampled with the ack.
- Bus2IP_CS, Bus2IP_RNW  out  1 each: chip select and direction.
- Bus2IP_Addr  out  C_S_AXI_ADDR_WIDTH: address.
- Bus2IP_Data  out  C_S_AXI_DATA_WIDTH: write data.
- Bus2IP_BE  out  C_S_AXI_DATA_WIDTH/8: byte enables.
- IP2Bus_Data  in  C_S_AXI_DATA_WIDTH: read data.
- IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error  in  1 each.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command and go to ACCESS.
  - ACCESS: Bus2IP_CS=1 and all bus outputs are held stable. Completion:
    - A read completes only on IP2Bus_RdAck.
    - A write completes only on IP2Bus_WrAck.
    - An ack of the wrong type is ignored.
    - On completion, capture IP2Bus_Data (reads), capture IP2Bus_Error, and go to GAP.
    - When the timeout counter reaches TIMEOUT_CYCLES, set rsp_error=1 and rsp_data=32'hDEAD_BEEF (reads and writes alike), then go to GAP.
  - GAP: exactly one cycle with CS=0. Any ack arriving in this cycle is discarded. This absorbs the second ack that a registered slave issues because CS is still high in the cycle of its first ack. Go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Acks arriving in IDLE, GAP or RESP are ignored and do not change state.
- Timeout counter: 16 bits. Cleared on entry to ACCESS, increments each ACCESS cycle without a valid ack, saturates.
- Each command produces exactly one response, in order. Only one command is outstanding at a time.
- Bus2IP_Addr/Data/BE/RNW keep their last values outside ACCESS. Only CS qualifies them.

## Timing
- Reset values (asynchronous): state=IDLE.
  - cmd_ready=0 during reset, 1 from the first cycle after release.
  - rsp_valid=0, rsp_data=0, rsp_error=0.
  - Bus2IP_CS=0, Bus2IP_RNW=1, Bus2IP_Addr=0, Bus2IP_Data=0, Bus2IP_BE=0.
- All outputs are registered, except that cmd_ready and rsp_valid decode directly from state.
- Latency with a one-cycle-ack slave:
  - Command handshake at edge 0.
  - CS high in cycle 1.
  - Ack in cycle 2.
  - GAP in cycle 3.
  - rsp_valid in cycle 4.
  - Minimum command-to-command spacing is 5 cycles when rsp_ready is held high.
- An ack sampled in the same cycle the counter reaches TIMEOUT_CYCLES wins: normal completion, no error.
- Reset asserted mid-access drops CS immediately, asynchronously. The pending response is lost.
- rsp_data and rsp_error are stable while rsp_valid=1 and rsp_ready=0.

## Structure
- Shared package nf10_ipif_pkg holds:
  - the state encoding (IDLE=0, ACCESS=1, GAP=2, RESP=3);
  - the timeout data constant 32'hDEAD_BEEF;
  - the counter width, 16.
- Single module; no sub-module. The timeout counter is small enough to stay inline.

## Test plan
- Write then read back against a ipif_regs instance (1 WO, 8 RW, 12 RO):
  - write 0x1234_5678 to address 0x4;
  - read 0x4 -> rsp_data=0x1234_5678, rsp_error=0;
  - exactly one response per command;
  - the duplicate ack in GAP is dropped.
- Read of WO address 0x0 (slave never acks):
  - after TIMEOUT_CYCLES=8 cycles of CS -> rsp_error=1, rsp_data=0xDEAD_BEEF;
  - CS deasserts the next cycle.
- Write to an RO address -> the WrAck is honoured, and rsp_error=0.
- Backpressure:
  - hold rsp_ready=0 for 10 cycles;
  - response stays stable;
  - cmd_ready=0 throughout;
  - CS stays 0.
- Ack coincident with the timeout boundary (slave stub acks on cycle 8, TIMEOUT_CYCLES=8) -> rsp_error=0, with data captured.
- Assert Bus2IP_Resetn=0 in the middle of ACCESS:
  - CS goes to 0 without waiting for a clock edge;
  - after release, cmd_ready=1 and no stale response appears.
